// File: rtl/branch_pkg.sv
// Shared constants for the branch predict unit: MIPS branch opcodes, REGIMM rt sub-ops
// and the 2-bit saturating counter encoding with its next-state helper.
package branch_pkg;

  localparam logic [5:0] REGIMM = 6'h01;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] BLEZ   = 6'h06;
  localparam logic [5:0] BGTZ   = 6'h07;

  localparam logic [4:0] BLTZ   = 5'h00;
  localparam logic [4:0] BGEZ   = 5'h01;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Saturating step toward the observed direction
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    case (c)
      SNT:     return taken ? WNT : SNT;
      WNT:     return taken ? WT  : SNT;
      WT:      return taken ? ST  : WNT;
      default: return taken ? ST  : WT;
    endcase
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side prediction and execute-side resolution signals of the branch predict unit.
// Stats outputs exist only when BRANCH_PREDICT_STATS_EN is defined.
interface branch_predict_unit_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) ();
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic              pred_valid;
  logic              pred_taken;

  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic [5:0]        ex_opcode;
  logic [4:0]        ex_rt;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic              ex_pred_taken;
  logic              res_valid;
  logic              branch_exec;
  logic              mispredict;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispredicts;
`endif

  modport master (
    output if_valid, if_pc, ex_valid, ex_pc, ex_opcode, ex_rt, ex_rs_data, ex_rt_data, ex_pred_taken,
`ifdef BRANCH_PREDICT_STATS_EN
    input  stat_branches, stat_mispredicts,
`endif
    input  pred_valid, pred_taken, res_valid, branch_exec, mispredict
  );

  modport slave (
    input  if_valid, if_pc, ex_valid, ex_pc, ex_opcode, ex_rt, ex_rs_data, ex_rt_data, ex_pred_taken,
`ifdef BRANCH_PREDICT_STATS_EN
    output stat_branches, stat_mispredicts,
`endif
    output pred_valid, pred_taken, res_valid, branch_exec, mispredict
  );
endinterface

// File: rtl/branch_predict_unit_cond.sv
// Combinational branch condition evaluation: flags recognised branches and their direction.
module branch_cond
  import branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        i_opcode,
  input  logic [4:0]        i_rt,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  output logic              o_is_branch,
  output logic              o_taken
);
  logic w_neg, w_zero;

  assign w_neg  = i_rs_data[DATA_W-1];
  assign w_zero = (i_rs_data == '0);

  always_comb begin
    o_is_branch = 1'b0;
    o_taken     = 1'b0;
    case (i_opcode)
      BEQ:  begin o_is_branch = 1'b1; o_taken = (i_rs_data == i_rt_data); end
      BNE:  begin o_is_branch = 1'b1; o_taken = (i_rs_data != i_rt_data); end
      BLEZ: begin o_is_branch = 1'b1; o_taken = w_neg | w_zero;           end
      BGTZ: begin o_is_branch = 1'b1; o_taken = ~w_neg & ~w_zero;         end
      REGIMM: begin
        if (i_rt == BLTZ) begin
          o_is_branch = 1'b1;
          o_taken     = w_neg;
        end else if (i_rt == BGEZ) begin
          o_is_branch = 1'b1;
          o_taken     = ~w_neg;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: BHT of 2-bit counters read at fetch, trained at execute.
// Optional BRANCH_PREDICT_STATS_EN adds saturating branch / mispredict counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int PC_W      = 32,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  ctr_t             r_bht [BHT_DEPTH];
  logic [IDX_W-1:0] w_if_idx, w_ex_idx;
  ctr_t             w_if_ctr;
  logic             w_is_branch, w_taken, w_upd;
  logic             r_pred_valid, r_pred_taken, r_res_valid, r_branch_exec, r_mispredict;
  logic             w_unused;

  assign w_if_idx = bus.if_pc[IDX_W+1:2];
  assign w_ex_idx = bus.ex_pc[IDX_W+1:2];
  assign w_if_ctr = r_bht[w_if_idx];
  assign w_unused = ^{bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0],
                      bus.ex_pc[PC_W-1:IDX_W+2], bus.ex_pc[1:0]};

  branch_cond #(.DATA_W(DATA_W)) u_cond (
    .i_opcode    (bus.ex_opcode),
    .i_rt        (bus.ex_rt),
    .i_rs_data   (bus.ex_rs_data),
    .i_rt_data   (bus.ex_rt_data),
    .o_is_branch (w_is_branch),
    .o_taken     (w_taken)
  );

  assign w_upd = bus.ex_valid & w_is_branch;

  // Prediction reads the registered table, so a same-cycle update is not bypassed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_res_valid   <= 1'b0;
      r_branch_exec <= 1'b0;
      r_mispredict  <= 1'b0;
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= WNT;
    end else begin
      r_pred_valid  <= bus.if_valid;
      r_pred_taken  <= bus.if_valid & w_if_ctr[1];
      r_res_valid   <= w_upd;
      r_branch_exec <= w_upd & w_taken;
      r_mispredict  <= w_upd & (w_taken ^ bus.ex_pred_taken);
      if (w_upd) r_bht[w_ex_idx] <= ctr_next(r_bht[w_ex_idx], w_taken);
    end
  end

  assign bus.pred_valid  = r_pred_valid;
  assign bus.pred_taken  = r_pred_taken;
  assign bus.res_valid   = r_res_valid;
  assign bus.branch_exec = r_branch_exec;
  assign bus.mispredict  = r_mispredict;

`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] r_stat_br, r_stat_mp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (w_upd) begin
      if (r_stat_br != '1) r_stat_br <= r_stat_br + 32'd1;
      if ((w_taken ^ bus.ex_pred_taken) && r_stat_mp != '1) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign bus.stat_branches    = r_stat_br;
  assign bus.stat_mispredicts = r_stat_mp;
`endif
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter BHT_DEPTH, default 16, number of 2-bit history counters (power of 2, 4..1024).
REQ-002 SHALL have parameter PC_W, default 32, program-counter width.
REQ-003 SHALL have parameter DATA_W, default 32, register-operand width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 if_valid  input  1  fetch-stage prediction request.
REQ-007 if_pc  input  PC_W  fetch PC.
REQ-008 pred_valid  output  1  prediction valid, one cycle after if_valid.
REQ-009 pred_taken  output  1  predicted direction.
REQ-010 ex_valid  input  1  execute-stage branch-control enable, replacing Branch_ctrl.
REQ-011 ex_pc  input  PC_W  PC of resolving instruction.
REQ-012 ex_opcode  input  6  instruction opcode.
REQ-013 ex_rt  input  5  rt field (REGIMM sub-op).
REQ-014 ex_rs_data, ex_rt_data  input  DATA_W each  source operands.
REQ-015 ex_pred_taken  input  1  prediction carried down the pipe for this instruction.
REQ-016 res_valid  output  1  resolution valid.
REQ-017 branch_exec  output  1  branch actually taken.
REQ-018 mispredict  output  1  actual direction differs from ex_pred_taken; pipeline flush request.

Function
REQ-019 Conditions SHALL be: BEQ 6'h04 rs==rt; BNE 6'h05 rs!=rt; BLEZ 6'h06 signed rs<=0; BGTZ 6'h07 signed rs>0; REGIMM 6'h01 with rt 5'h00 BLTZ signed rs<0, rt 5'h01 BGEZ signed rs>=0.
REQ-020 Any other opcode/rt, or ex_valid=0, SHALL produce res_valid=0, branch_exec=0, mispredict=0 and no table update.
REQ-021 BHT index SHALL be pc[log2(BHT_DEPTH)+1:2] for both if_pc and ex_pc.
REQ-022 pred_valid/pred_taken SHALL be registered: cycle N if_valid -> cycle N+1 outputs; pred_taken = counter MSB; pred_taken=0 when pred_valid=0.
REQ-023 res_valid/branch_exec/mispredict SHALL be registered, latency one cycle from ex_valid.
REQ-024 On a valid recognised branch, the indexed counter SHALL increment (taken) or decrement (not taken), saturating at 2'b11 and 2'b00.
REQ-025 Same-cycle prediction read and update of the same index SHALL return the pre-update counter value (no bypass).
REQ-026 Back-to-back resolutions of the same index on consecutive cycles SHALL each apply to the result of the previous update.
REQ-027 Operand compare SHALL use full DATA_W width; signed tests use bit DATA_W-1.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear pred_valid, pred_taken, res_valid, branch_exec, mispredict to 0.
REQ-029 Reset SHALL set every BHT counter to 2'b01 (weakly not-taken), including mid-operation; an update in the reset-release cycle SHALL be lost only if rst_n is low at the edge.

Configuration
REQ-030 Macro BRANCH_PREDICT_STATS_EN SHALL, when defined, add outputs stat_branches and stat_mispredicts (32 bits each), counting valid recognised branches and mispredicts, saturating at 32'hFFFFFFFF, reset to 0.
REQ-031 Without BRANCH_PREDICT_STATS_EN these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Package branch_pkg SHALL hold opcode constants (BEQ, BNE, BLEZ, BGTZ, REGIMM), REGIMM rt codes (BLTZ, BGEZ) and counter encodings SNT=00, WNT=01, WT=10, ST=11.
REQ-033 Condition evaluation SHALL be a combinational sub-module branch_cond (opcode, rt, rs_data, rt_data -> is_branch, taken).

Verification
REQ-034 Reset, then if_valid with if_pc=32'h0000_0040 -> next cycle pred_valid=1, pred_taken=0.
REQ-035 BEQ at pc 32'h40, rs=rt=32'h5, ex_pred_taken=0 -> branch_exec=1, mispredict=1; repeat -> counter 11, later prediction for pc 32'h40 =1.
REQ-036 BLTZ rs=32'h8000_0000 -> taken; BGEZ rs=32'h0 -> taken; BGTZ rs=32'h0 -> not taken; BLEZ rs=32'hFFFF_FFFF -> taken.
REQ-037 Opcode 6'h23 with ex_valid=1 -> res_valid=0, branch_exec=0, counter unchanged.
REQ-038 Same-cycle predict and update of index 3 at counter 01, taken -> pred_taken=0 that cycle, 1 on next read.
REQ-039 rst_n low mid-stream after saturating index 0 to 11 -> outputs 0 immediately, index 0 predicts not-taken afterwards; with BRANCH_PREDICT_STATS_EN, stat counters read 0.
